// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, read-return and RAM-port signals of the node memory front end
interface mem_arbiter_if #(
   parameter int AW = 10,
   parameter int DW = 69
);
   logic          m0_req, m1_req;
   logic          m0_we, m1_we;
   logic          m0_lock, m1_lock;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic          m0_ack, m1_ack;
   logic          m0_rvalid, m1_rvalid;
   logic [DW-1:0] rdata;
   logic          init_done;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data;
   logic          ram_wren;
   logic [DW-1:0] ram_q;

   modport master (
      output m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock,
      output m0_addr, m1_addr, m0_wdata, m1_wdata, ram_q,
      input  m0_ack, m1_ack, m0_rvalid, m1_rvalid, rdata, init_done,
      input  ram_address, ram_data, ram_wren
   );

   modport slave (
      input  m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock,
      input  m0_addr, m1_addr, m0_wdata, m1_wdata, ram_q,
      output m0_ack, m1_ack, m0_rvalid, m1_rvalid, rdata, init_done,
      output ram_address, ram_data, ram_wren
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: zeroes the shared node RAM after reset, then round-robin shares its port between two requesters with an atomic lock
module mem_arbiter #(
   parameter int CLEAR_DEPTH = 69,
   parameter int AW          = 10,
   parameter int DW          = 69
) (
   input  logic         clock,
   input  logic         reset,
   mem_arbiter_if.slave bus
);
   typedef enum logic {INIT, RUN} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] clr_cnt_q, clr_cnt_d;
   logic [AW-1:0] addr_q;
   logic          prio_q, prio_d;
   logic          lock_valid_q, lock_valid_d;
   logic          owner_q, owner_d;
   logic          rv0_q, rv1_q;
   logic          g0, g1, wren;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;

   // state, sweep counter, arbitration bookkeeping and read-return flags
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= INIT;
         clr_cnt_q    <= '0;
         prio_q       <= 1'b0;
         lock_valid_q <= 1'b0;
         owner_q      <= 1'b0;
         rv0_q        <= 1'b0;
         rv1_q        <= 1'b0;
         addr_q       <= '0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         prio_q       <= prio_d;
         lock_valid_q <= lock_valid_d;
         owner_q      <= owner_d;
         rv0_q        <= g0 & ~bus.m0_we;
         rv1_q        <= g1 & ~bus.m1_we;
         addr_q       <= addr;
      end
   end

   // clear sweep in INIT, grant selection and RAM port mux in RUN
   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      prio_d       = prio_q;
      lock_valid_d = lock_valid_q;
      owner_d      = owner_q;
      g0           = 1'b0;
      g1           = 1'b0;
      wren         = 1'b0;
      addr         = addr_q;
      data         = '0;
      if (state_q == INIT) begin
         wren      = 1'b1;
         addr      = clr_cnt_q;
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == AW'(CLEAR_DEPTH - 1)) state_d = RUN;
      end else if (reset) begin
         if (lock_valid_q) begin
            g0 = !owner_q && bus.m0_req;
            g1 = owner_q && bus.m1_req;
            if (!(owner_q ? bus.m1_req : bus.m0_req)) lock_valid_d = 1'b0;
         end else begin
            g0 = bus.m0_req && (!bus.m1_req || !prio_q);
            g1 = bus.m1_req && (!bus.m0_req || prio_q);
         end
         if (g0 || g1) begin
            prio_d       = g0;
            owner_d      = g1;
            lock_valid_d = g1 ? bus.m1_lock : bus.m0_lock;
            wren         = g1 ? bus.m1_we : bus.m0_we;
            addr         = g1 ? bus.m1_addr : bus.m0_addr;
            data         = g1 ? bus.m1_wdata : bus.m0_wdata;
         end
      end
   end

   assign bus.ram_wren    = wren & reset;
   assign bus.ram_address = addr;
   assign bus.ram_data    = data;
   assign bus.m0_ack      = g0;
   assign bus.m1_ack      = g1;
   assign bus.m0_rvalid   = rv0_q;
   assign bus.m1_rvalid   = rv1_q;
   assign bus.rdata       = bus.ram_q;
   assign bus.init_done   = (state_q == RUN);
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Front-end controller for the shared 69-bit node memory (`single_port_ram`: 10-bit address, one access per clock, read data one cycle after the address). After reset it sweeps the RAM to zero, because the RAM array has no reset. It then shares the single port between two requesters, for example the traversal engine and the execute/GC unit. Arbitration is round-robin with an optional lock that keeps read-modify-write sequences atomic.

## Interface
Parameters:
- `CLEAR_DEPTH`, default 69: number of RAM words zeroed after reset (addresses 0..CLEAR_DEPTH-1); equals the instantiated array depth.
- `AW`, default 10: address width.
- `DW`, default 69: data width.

Ports (one clock; reset is synchronous and active-low):
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  access request; held high until acked.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read; held with req.
- `m0_lock`, `m1_lock`  in  1  keep ownership after this grant.
- `m0_addr`, `m1_addr`  in  AW  word address.
- `m0_wdata`, `m1_wdata`  in  DW  write data.
- `m0_ack`, `m1_ack`  out  1  combinational; the access is issued this cycle.
- `m0_rvalid`, `m1_rvalid`  out  1  registered; `rdata` is valid this cycle.
- `rdata`  out  DW  direct pass-through of `ram_q`, shared by both requesters.
- `init_done`  out  1  high once the clear sweep has finished.
- `ram_address`  out  AW  to RAM `address`.
- `ram_data`  out  DW  to RAM `data`.
- `ram_wren`  out  1  to RAM `wren`.
- `ram_q`  in  DW  from RAM `q`.

## Operation
- FSM has two states:
  - INIT: clear sweep.
  - RUN: arbitration.
- Any cycle with `reset` low moves the FSM to INIT on the next edge. It also zeroes clr_cnt, sets prio to 0, clears lock_valid and clears both rvalid registers.
- While `reset` is low, `ram_wren` is forced to 0 combinationally.
- INIT:
  - Drives `ram_wren`=1, `ram_address`=clr_cnt, `ram_data`=0.
  - clr_cnt increments each cycle. When clr_cnt==CLEAR_DEPTH-1, the next state is RUN.
  - Both acks are 0 and `init_done` is 0.
- RUN: each cycle at most one requester is granted.
  - Lock active (lock_valid=1, owner=k): only mk may be granted.
  - The other requester waits even when mk is idle.
  - Lock is cleared when mk is granted with lock=0, or when mk_req is low during a RUN cycle.
  - No lock, both requesting: grant m[prio]; then prio becomes the other index.
  - No lock, one requesting: grant it; prio becomes the other index.
  - Grant with lock=1: set lock_valid, owner=granted index.
- On a grant:
  - The granted requester's address, data and we are muxed combinationally onto `ram_address`, `ram_data` and `ram_wren`.
  - Its ack is 1 that cycle.
  - A write completes at that edge.
  - A read sets that requester's rvalid register, so rvalid is high in the following cycle.
- No grant in RUN: `ram_wren`=0; `ram_address` holds the last driven value (don't care).
- Reads and writes pipeline back-to-back with no bubble. A read granted immediately after a write to the same address returns the new data.

## Timing
- Reset values: all acks 0, both rvalids 0, `init_done` 0, `ram_wren` 0.
- Clear latency: exactly CLEAR_DEPTH cycles from the first edge with `reset` high to the first RUN cycle. With the default, `init_done` rises 69 cycles after reset release.
- Write: ack in cycle N; RAM updated at the end of N.
- Read: ack in cycle N; rvalid and `rdata` valid in cycle N+1 only.
- Throughput: one access per cycle, total across both requesters.
- Requests raised during INIT stay pending and are arbitrated from the first RUN cycle.
- Reset mid-RUN:
  - A pending rvalid is dropped.
  - No ack is issued while `reset` is low.
  - The full clear sweep reruns.

## Test plan
- Reset release, no requests: `ram_wren`=1 for 69 cycles on addresses 0..68 with data 0, then `init_done`=1; a read of address 5 returns 0.
- m0 writes 0x1_2345 to address 10; next cycle m0 reads address 10: ack in both cycles, rvalid on the third cycle, `rdata`=0x1_2345.
- m0 and m1 hold continuous reads from RUN entry: acks alternate m0, m1, m0, m1, and each rvalid follows its own ack by one cycle.
- m0 sets lock on a read of address 3, then writes address 3 with lock=0 while m1 requests throughout: m1 is acked only after the m0 write.
- m1 reads in cycle N and `reset` goes low in N: no rvalid in N+1; the sweep restarts from address 0.
- m0 requests during INIT: no ack until the first RUN cycle, then ack in that cycle.
